// File: rtl/alu_ccr_controller_pkg.sv
// Shared definitions for the ALU condition-code controller.
//   - ALU opcode defines (guarded so an existing definition wins) and
//     typed localparam copies of the opcodes the controller decodes
//   - CCR bit indices, packed as {V,C,N,Z}
//   - controller state encoding
//   - jumpDecision(): conditional-jump resolution from a flag vector
// No ports: this is a package.

`ifndef ALU_OPCODE_DEFINES
`define ALU_OPCODE_DEFINES
`define ALU_ADD  5'h00
`define ALU_SUB  5'h01
`define ALU_AND  5'h02
`define ALU_OR   5'h03
`define ALU_XOR  5'h04
`define ALU_SHL  5'h05
`define ALU_SHR  5'h06
`define ALU_CMP  5'h07
`define ALU_JZ   5'h10
`define ALU_JN   5'h11
`define ALU_JC   5'h12
`define ALU_JMP  5'h13
`define ALU_NOP  5'h1F
`endif

package alu_ccr_controller_pkg;

  localparam int CCR_Z = 0;
  localparam int CCR_N = 1;
  localparam int CCR_C = 2;
  localparam int CCR_V = 3;

  localparam logic [4:0] ALU_OP_ADD = `ALU_ADD;
  localparam logic [4:0] ALU_OP_JZ  = `ALU_JZ;
  localparam logic [4:0] ALU_OP_JN  = `ALU_JN;
  localparam logic [4:0] ALU_OP_JC  = `ALU_JC;
  localparam logic [4:0] ALU_OP_JMP = `ALU_JMP;
  localparam logic [4:0] ALU_OP_NOP = `ALU_NOP;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    SAVE    = 2'd2,
    RESTORE = 2'd3
  } ctrlState_t;

  function automatic logic jumpDecision(input logic [4:0] op, input logic [3:0] flags);
    logic taken;
    taken = 1'b0;
    case (op)
      ALU_OP_JZ:  taken = flags[CCR_Z];
      ALU_OP_JN:  taken = flags[CCR_N];
      ALU_OP_JC:  taken = flags[CCR_C];
      ALU_OP_JMP: taken = 1'b1;
      default:    taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_ccr_controller_stack.sv
// ccr_shadow_stack: LIFO of DEPTH x 4-bit CCR snapshots.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the stack)
//   push, pushData  write pushData on top; ignored when full
//   pop             drop the top entry; ignored when empty
//   topData         most recent entry (0 when empty)
//   full, empty     occupancy flags

module ccr_shadow_stack #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] pushData,
  output logic [3:0] topData,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] ptr;
  logic [3:0]    entries [DEPTH];
  logic [IW-1:0] wrIdx;
  logic [IW-1:0] topIdx;

  assign full   = (ptr == PW'(DEPTH));
  assign empty  = (ptr == '0);
  assign wrIdx  = IW'(ptr);
  assign topIdx = IW'(ptr - PW'(1));
  assign topData = empty ? 4'b0000 : entries[topIdx];

  // Pointer saturates at both ends, so it never wraps or underflows.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= 4'b0000;
    end else if (push && !full) begin
      entries[wrIdx] <= pushData;
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PW'(1);
    end
  end

endmodule

// File: rtl/alu_ccr_controller.sv
// alu_ccr_controller: owns the {V,C,N,Z} condition-code register around the
// execute-stage ALU, resolves conditional jumps from it, and saves/restores
// it through a shadow stack on interrupt entry / RTI.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ex_valid, stall, flush       execute-stage qualifiers for flag commit
//   alu_signals                  ALU opcode (`ALU_* encoding)
//   alu_flags_out / alu_flags_in flags from / to the ALU
//   ccr                          architectural flags
//   branch_taken                 combinational jump decision
//   int_req / int_ack            interrupt snapshot handshake (level / pulse)
//   rti / rti_done               restore handshake (level / pulse)
//   stall_req                    pipeline freeze during SAVE and RESTORE
//   stack_full, stack_err        shadow stack full; sticky pop-on-empty
//
// state   | meaning
// RUN     | normal execution, flags commit, accepts int_req / rti
// DRAIN   | flags still commit while in-flight instructions finish
// SAVE    | pipeline frozen, ccr pushed, int_ack pulsed
// RESTORE | pipeline frozen, ccr popped (or stack_err set), rti_done pulsed

module alu_ccr_controller
  import alu_ccr_controller_pkg::*;
#(
  parameter int SHADOW_DEPTH = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic [4:0] alu_signals,
  input  logic [3:0] alu_flags_out,
  output logic [3:0] alu_flags_in,
  output logic [3:0] ccr,
  output logic       branch_taken,
  input  logic       int_req,
  output logic       int_ack,
  input  logic       rti,
  output logic       rti_done,
  output logic       stall_req,
  output logic       stack_full,
  output logic       stack_err
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrlState_t    state, nextState;
  logic [CW-1:0] drainCnt, nextCnt;
  logic          commitOk;
  logic          doPush, doPop;
  logic [3:0]    stackTop;
  logic          stackFull, stackEmpty;

  ccr_shadow_stack #(.DEPTH(SHADOW_DEPTH)) uStack (
    .clk      (clk),
    .rst      (rst),
    .push     (doPush),
    .pop      (doPop),
    .pushData (ccr),
    .topData  (stackTop),
    .full     (stackFull),
    .empty    (stackEmpty)
  );

  assign stack_full   = stackFull;
  assign alu_flags_in = ccr;
  assign branch_taken = ex_valid && !flush && jumpDecision(alu_signals, ccr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      drainCnt <= '0;
    end else begin
      state    <= nextState;
      drainCnt <= nextCnt;
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = drainCnt;
    commitOk  = 1'b0;
    doPush    = 1'b0;
    doPop     = 1'b0;
    int_ack   = 1'b0;
    rti_done  = 1'b0;
    stall_req = 1'b0;
    case (state)
      RUN: begin
        commitOk = 1'b1;
        // A full stack leaves int_req pending, which lets a waiting rti through.
        if (int_req && !stackFull) begin
          nextState = DRAIN;
          nextCnt   = CW'(DRAIN_CYCLES - 1);
        end else if (rti) begin
          nextState = RESTORE;
        end
      end
      DRAIN: begin
        commitOk = 1'b1;
        if (drainCnt == '0) nextState = SAVE;
        else                nextCnt   = drainCnt - CW'(1);
      end
      SAVE: begin
        stall_req = 1'b1;
        doPush    = 1'b1;
        int_ack   = 1'b1;
        nextState = RUN;
      end
      RESTORE: begin
        stall_req = 1'b1;
        doPop     = 1'b1;
        rti_done  = 1'b1;
        nextState = RUN;
      end
      default: nextState = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr       <= 4'b0000;
      stack_err <= 1'b0;
    end else if (doPop) begin
      if (!stackEmpty) ccr <= stackTop;
      else             stack_err <= 1'b1;
    end else if (commitOk && ex_valid && !stall && !flush) begin
      ccr <= alu_flags_out;
    end
  end

endmodule

// File: tb/tb_alu_ccr_controller.sv
// Self-checking bench for alu_ccr_controller: directed scenarios followed by
// randomized traffic, checked against a schedule-based reference model.
module tb_alu_ccr_controller;
  import alu_ccr_controller_pkg::*;

  localparam int DEPTH = 2;
  localparam int DRAIN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ex_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0] alu_signals = ALU_OP_NOP;
  logic [3:0] alu_flags_out = 4'b0000;
  logic       int_req = 1'b0, rti = 1'b0;
  logic [3:0] alu_flags_in, ccr;
  logic       branch_taken, int_ack, rti_done, stall_req, stack_full, stack_err;

  always #5 clk = ~clk;

  alu_ccr_controller #(.SHADOW_DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall), .flush(flush),
    .alu_signals(alu_signals), .alu_flags_out(alu_flags_out),
    .alu_flags_in(alu_flags_in), .ccr(ccr), .branch_taken(branch_taken),
    .int_req(int_req), .int_ack(int_ack), .rti(rti), .rti_done(rti_done),
    .stall_req(stall_req), .stack_full(stack_full), .stack_err(stack_err)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Reference model: flags, a queue used as the snapshot stack, and the
  // absolute edge numbers at which a pending push / pop takes effect.
  logic [3:0] mCcr = 4'b0000;
  logic [3:0] mStack[$];
  bit         mErr = 1'b0;
  int         saveAt = -1;
  int         restoreAt = -1;

  typedef struct { bit isAck; int cyc; } evt_t;
  evt_t expQ[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic bit refBranch(input bit v, input bit f, input logic [4:0] op,
                                   input logic [3:0] flags);
    if (!v || f) return 1'b0;
    if (op == ALU_OP_JZ)  return flags[0];
    if (op == ALU_OP_JN)  return flags[1];
    if (op == ALU_OP_JC)  return flags[2];
    if (op == ALU_OP_JMP) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mCcr = 4'b0000;
      mStack.delete();
      mErr = 1'b0;
      saveAt = -1;
      restoreAt = -1;
      expQ.delete();
    end else if (cyc == saveAt) begin
      mStack.push_back(mCcr);
      saveAt = -1;
    end else if (cyc == restoreAt) begin
      if (mStack.size() > 0) mCcr = mStack.pop_back();
      else mErr = 1'b1;
      restoreAt = -1;
    end else begin
      if (ex_valid && !stall && !flush) mCcr = alu_flags_out;
      if (saveAt < 0 && restoreAt < 0) begin
        if (int_req && mStack.size() < DEPTH) begin
          saveAt = cyc + DRAIN + 1;
          expQ.push_back('{1'b1, cyc + DRAIN});
        end else if (rti) begin
          restoreAt = cyc + 1;
          expQ.push_back('{1'b0, cyc});
        end
      end
    end
  end

  always @(negedge clk) begin
    bit expAck, expDone;
    if (cyc > 0) begin
      chk("ccr", int'(ccr), int'(mCcr));
      chk("alu_flags_in", int'(alu_flags_in), int'(mCcr));
      chk("stall_req", int'(stall_req), int'((saveAt == cyc + 1) || (restoreAt == cyc + 1)));
      chk("stack_full", int'(stack_full), int'(mStack.size() == DEPTH));
      chk("stack_err", int'(stack_err), int'(mErr));
      expAck  = (expQ.size() > 0) && (expQ[0].cyc == cyc) && expQ[0].isAck;
      expDone = (expQ.size() > 0) && (expQ[0].cyc == cyc) && !expQ[0].isAck;
      if (int_ack || expAck)   chk("int_ack", int'(int_ack), int'(expAck));
      if (rti_done || expDone) chk("rti_done", int'(rti_done), int'(expDone));
      if (expAck || expDone) void'(expQ.pop_front());
    end
  end

  task automatic step(input bit v, input bit s, input bit f,
                      input logic [4:0] op, input logic [3:0] fl);
    @(negedge clk);
    if (int_ack)  int_req = 1'b0;
    if (rti_done) rti = 1'b0;
    ex_valid = v; stall = s; flush = f; alu_signals = op; alu_flags_out = fl;
    #1;
    chk("branch_taken", int'(branch_taken), int'(refBranch(v, f, op, mCcr)));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, ALU_OP_NOP, 4'b0000);
  endtask

  task automatic commit(input logic [3:0] fl);
    step(1'b1, 1'b0, 1'b0, ALU_OP_ADD, fl);
  endtask

  task automatic waitIdle(input string name, input int maxc);
    int n = 0;
    while ((int_req || rti) && n < maxc) begin
      idle(1);
      n++;
    end
    chk({"handshake timeout ", name}, int'(int_req || rti), 0);
    int_req = 1'b0;
    rti = 1'b0;
    idle(1);
  endtask

  task automatic doReset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  function automatic logic [4:0] randOp;
    case ($urandom_range(0, 5))
      0: return ALU_OP_JZ;
      1: return ALU_OP_JN;
      2: return ALU_OP_JC;
      3: return ALU_OP_JMP;
      4: return ALU_OP_NOP;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    doReset();

    // Commit gating: flush, then stall, then a clean commit of 1011.
    step(1'b1, 1'b0, 1'b1, ALU_OP_ADD, 4'b1011);
    step(1'b1, 1'b1, 1'b0, ALU_OP_ADD, 4'b1011);
    commit(4'b1011);
    idle(1);

    // Branch decisions with ccr = 0001 (stall suppresses further commits).
    commit(4'b0001);
    step(1'b1, 1'b1, 1'b0, ALU_OP_JZ,  4'b0000);
    step(1'b1, 1'b1, 1'b0, ALU_OP_JN,  4'b0000);
    step(1'b1, 1'b1, 1'b0, ALU_OP_JMP, 4'b0000);
    step(1'b1, 1'b1, 1'b1, ALU_OP_JZ,  4'b0000);
    step(1'b1, 1'b1, 1'b0, ALU_OP_JC,  4'b0000);
    step(1'b0, 1'b0, 1'b0, ALU_OP_JMP, 4'b0000);

    // Interrupt save of 0101, restored on RTI.
    commit(4'b0101);
    int_req = 1'b1;
    waitIdle("save0101", 20);
    commit(4'b1111);
    rti = 1'b1;
    waitIdle("rti0101", 20);

    // Commit during DRAIN is the value captured.
    commit(4'b0101);
    int_req = 1'b1;
    idle(1);
    commit(4'b0010);
    waitIdle("drainCommit", 20);
    commit(4'b0000);
    rti = 1'b1;
    waitIdle("rti0010", 20);

    // Nested saves, overflow hold-off, release by RTI.
    doReset();
    commit(4'b0001);
    int_req = 1'b1;
    waitIdle("nest1", 20);
    commit(4'b0010);
    int_req = 1'b1;
    waitIdle("nest2", 20);
    commit(4'b0100);
    int_req = 1'b1;
    idle(6);
    rti = 1'b1;
    waitIdle("overflowRelease", 30);
    repeat (3) begin
      rti = 1'b1;
      waitIdle("unwind", 20);
    end

    // Restore then underflow; stack_err is sticky.
    doReset();
    commit(4'b1100);
    int_req = 1'b1;
    waitIdle("save1100", 20);
    commit(4'b0011);
    rti = 1'b1;
    waitIdle("rti1100", 20);
    rti = 1'b1;
    waitIdle("underflow", 20);
    commit(4'b1010);
    idle(3);

    // int_req and rti together: interrupt first, rti afterwards.
    doReset();
    commit(4'b0110);
    int_req = 1'b1;
    rti = 1'b1;
    waitIdle("intAndRti", 30);

    // Reset in the middle of DRAIN: no ack may follow.
    commit(4'b1001);
    int_req = 1'b1;
    idle(2);
    rst = 1'b1;
    int_req = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (!int_req && $urandom_range(0, 15) == 0) int_req = 1'b1;
      if (!rti && $urandom_range(0, 19) == 0) rti = 1'b1;
      rst = ($urandom_range(0, 149) == 0);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), randOp(), 4'($urandom));
    end
    rst = 1'b0;
    if (int_req && mStack.size() == DEPTH) rti = 1'b1;
    waitIdle("final", 60);
    idle(4);
    chk("pending events", expQ.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
